// File: rtl/button_conditioner.sv
// button_conditioner: synchronised, debounced submit/clear pulses plus a filtered switch word snapshot
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES  = 1_000_000,
    parameter int SW_STABLE_CYCLES = 100_000,
    parameter int SW_WIDTH         = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                submit_btn,
    input  logic                clear_btn,
    input  logic [SW_WIDTH-1:0] sw,
    output logic                submit_pulse,
    output logic                clear_pulse,
    output logic [SW_WIDTH-1:0] sw_value,
    output logic [SW_WIDTH-1:0] sw_stable
);
    localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > SW_STABLE_CYCLES) ? DEBOUNCE_CYCLES : SW_STABLE_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] SW_LAST = CW'(SW_STABLE_CYCLES - 1);
    localparam logic RELEASED = 1'b0;
    localparam logic PRESSED  = 1'b1;

    // bit 0 is the submit button, bit 1 the clear button
    logic [1:0]          btn_s1_q, btn_s2_q;
    logic [1:0]          state_q, state_d;
    logic [1:0]          pulse_q, pulse_d;
    logic [1:0]          moving, done;
    logic [1:0][CW-1:0]  cnt_q, cnt_d;
    logic [SW_WIDTH-1:0] sw_s1_q, sw_s2_q, sw_prev_q, sw_stable_q, sw_value_q;
    logic [CW-1:0]       stab_q, stab_d;

    for (genvar b = 0; b < 2; b++) begin : g_btn
        assign moving[b]  = (state_q[b] == RELEASED) ? btn_s2_q[b] : !btn_s2_q[b];
        assign done[b]    = moving[b] && (cnt_q[b] == DB_LAST);
        assign cnt_d[b]   = (!moving[b] || done[b]) ? '0 : cnt_q[b] + 1'b1;
        assign state_d[b] = done[b] ? ((state_q[b] == RELEASED) ? PRESSED : RELEASED) : state_q[b];
        assign pulse_d[b] = done[b] && (state_q[b] == RELEASED);
    end

    // stab_d reaching SW_LAST means the word has been seen SW_STABLE_CYCLES samples in a row
    always_comb begin
        stab_d = (sw_s2_q != sw_prev_q) ? '0 : (stab_q == SW_LAST) ? stab_q : stab_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s1_q    <= '0;
            btn_s2_q    <= '0;
            state_q     <= {2{RELEASED}};
            cnt_q       <= '0;
            pulse_q     <= '0;
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            sw_prev_q   <= '0;
            stab_q      <= '0;
            sw_stable_q <= '0;
            sw_value_q  <= '0;
        end else begin
            btn_s1_q    <= {clear_btn, submit_btn};
            btn_s2_q    <= btn_s1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pulse_q     <= pulse_d;
            sw_s1_q     <= sw;
            sw_s2_q     <= sw_s1_q;
            sw_prev_q   <= sw_s2_q;
            stab_q      <= stab_d;
            sw_stable_q <= (stab_d == SW_LAST) ? sw_s2_q : sw_stable_q;
            sw_value_q  <= pulse_q[0] ? sw_stable_q : sw_value_q;
        end
    end

    assign submit_pulse = pulse_q[0];
    assign clear_pulse  = pulse_q[1];
    assign sw_value     = sw_value_q;
    assign sw_stable    = sw_stable_q;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: random and directed stimulus against a run-length reference model
module tb_button_conditioner;
    localparam int DB = 4;
    localparam int SS = 3;
    localparam int W  = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         submit_btn = 1'b0;
    logic         clear_btn = 1'b0;
    logic [W-1:0] sw = '0;
    logic         submit_pulse, clear_pulse;
    logic [W-1:0] sw_value, sw_stable;

    button_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .SW_STABLE_CYCLES(SS),
        .SW_WIDTH        (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .submit_btn  (submit_btn),
        .clear_btn   (clear_btn),
        .sw          (sw),
        .submit_pulse(submit_pulse),
        .clear_pulse (clear_pulse),
        .sw_value    (sw_value),
        .sw_stable   (sw_stable)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model: raw inputs delayed two samples, then run lengths of disagreeing / equal samples
    bit           armed = 0;
    int           cyc = 0;
    logic [1:0]   b_age1 = '0, b_age2 = '0;
    logic [W-1:0] s_age1 = '0, s_age2 = '0;
    logic [1:0]   m_pressed = '0, m_pulse = '0;
    int           m_run [2] = '{0, 0};
    logic [W-1:0] m_swlast = '0, m_stable = '0, m_value = '0;
    int           m_swrun = 1;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            armed = 1;
            b_age1 = '0;
            b_age2 = '0;
            s_age1 = '0;
            s_age2 = '0;
            m_pressed = '0;
            m_pulse = '0;
            m_run = '{0, 0};
            m_swlast = '0;
            m_swrun = 1;
            m_stable = '0;
            m_value = '0;
        end else begin
            if (m_pulse[0]) m_value = m_stable;
            for (int b = 0; b < 2; b++) begin
                m_pulse[b] = 1'b0;
                m_run[b] = (b_age2[b] != m_pressed[b]) ? m_run[b] + 1 : 0;
                if (m_run[b] == DB) begin
                    m_pressed[b] = !m_pressed[b];
                    m_run[b] = 0;
                    m_pulse[b] = m_pressed[b];
                end
            end
            m_swrun = (s_age2 == m_swlast) ? m_swrun + 1 : 1;
            m_swlast = s_age2;
            if (m_swrun >= SS) m_stable = s_age2;
            b_age2 = b_age1;
            b_age1 = {clear_btn, submit_btn};
            s_age2 = s_age1;
            s_age1 = sw;
        end
    end

    int n_sub = 0, n_clr = 0, last_sub = -1, last_clr = -1;

    always @(negedge clk) begin
        if (armed) begin
            check("submit_pulse", 32'(submit_pulse), 32'(m_pulse[0]));
            check("clear_pulse", 32'(clear_pulse), 32'(m_pulse[1]));
            check("sw_stable", 32'(sw_stable), 32'(m_stable));
            check("sw_value", 32'(sw_value), 32'(m_value));
            if (submit_pulse) begin
                n_sub++;
                last_sub = cyc;
            end
            if (clear_pulse) begin
                n_clr++;
                last_clr = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int c, n0, n1;

    initial begin
        tick(3);
        check("rst_submit", 32'(submit_pulse), 0);
        check("rst_clear", 32'(clear_pulse), 0);
        check("rst_sw_value", 32'(sw_value), 0);
        check("rst_sw_stable", 32'(sw_stable), 0);
        reset = 1'b0;
        sw = 10'd2;
        tick(10);
        check("sw_stable_2", 32'(sw_stable), 2);
        n0 = n_sub;
        submit_btn = 1'b1;
        c = cyc;
        tick(2);
        sw = 10'd5;
        tick(1);
        sw = 10'd2;
        tick(17);
        check("hold_one_pulse", 32'(n_sub - n0), 1);
        check("hold_latency", 32'(last_sub - c), 6);
        check("snapshot_glitch", 32'(sw_value), 2);
        submit_btn = 1'b0;
        tick(10);
        n0 = n_sub;
        for (int i = 0; i < 2; i++) begin
            submit_btn = 1'b1;
            tick(2);
            submit_btn = 1'b0;
            tick(2);
        end
        tick(2);
        check("bounce_no_pulse", 32'(n_sub - n0), 0);
        submit_btn = 1'b1;
        c = cyc;
        tick(12);
        check("bounce_one_pulse", 32'(n_sub - n0), 1);
        check("bounce_latency", 32'(last_sub - c), 6);
        submit_btn = 1'b0;
        sw = 10'd9;
        tick(10);
        n0 = n_sub;
        n1 = n_clr;
        submit_btn = 1'b1;
        clear_btn = 1'b1;
        tick(10);
        check("simul_submit", 32'(n_sub - n0), 1);
        check("simul_clear", 32'(n_clr - n1), 1);
        check("simul_same_cycle", 32'(last_sub - last_clr), 0);
        check("simul_sw_value", 32'(sw_value), 9);
        submit_btn = 1'b0;
        clear_btn = 1'b0;
        tick(10);
        submit_btn = 1'b1;
        tick(10);
        reset = 1'b1;
        tick(1);
        check("midrst_pulse", 32'(submit_pulse), 0);
        check("midrst_sw_value", 32'(sw_value), 0);
        check("midrst_sw_stable", 32'(sw_stable), 0);
        reset = 1'b0;
        n0 = n_sub;
        c = cyc;
        tick(10);
        check("midrst_repulse", 32'(n_sub - n0), 1);
        check("midrst_latency", 32'(last_sub - c), 6);
        submit_btn = 1'b0;
        tick(10);
        n0 = n_sub;
        n1 = n_clr;
        for (int i = 0; i < 15; i++) begin
            submit_btn = 1'b1;
            tick(10);
            submit_btn = 1'b0;
            tick(10);
        end
        tick(5);
        check("train_submit", 32'(n_sub - n0), 15);
        check("train_clear", 32'(n_clr - n1), 0);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(5) == 0) submit_btn = !submit_btn;
            if ($urandom_range(6) == 0) clear_btn = !clear_btn;
            if ($urandom_range(7) == 0) sw = W'($urandom_range(1023));
            reset = ($urandom_range(150) == 0);
            tick(1);
        end
        reset = 1'b0;
        tick(5);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
